// File: rtl/lsu_arbiter.sv
// Two-requester arbiter for the shared data-memory/IO bus: the CPU LSU (A) has
// priority, and the debug/DMA port (B) is forced through after STARVE_LIM denials.
module lsu_arbiter #(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_a_req,
   input  logic        i_a_we,
   input  logic [31:0] i_a_addr,
   input  logic [31:0] i_a_wdata,
   input  logic [3:0]  i_a_bmask,
   output logic        o_a_gnt,
   output logic        o_a_rvalid,
   output logic [31:0] o_a_rdata,
   input  logic        i_b_req,
   input  logic        i_b_we,
   input  logic [31:0] i_b_addr,
   input  logic [31:0] i_b_wdata,
   input  logic [3:0]  i_b_bmask,
   output logic        o_b_gnt,
   output logic        o_b_rvalid,
   output logic [31:0] o_b_rdata,
   output logic        o_mem_en,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_bmask,
   input  logic [31:0] i_mem_rdata,
   output logic        o_cpu_stall
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   logic [3:0] starve_cnt;
   owner_t     owner_p1;
   logic       rd_p1;
   logic       a_win;
   logic       b_win;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Grant decision: combinational, suppressed while reset is held
   always_comb begin
      b_win = i_rst_n && i_b_req && (!i_a_req || (starve_cnt >= LIM));
      a_win = i_rst_n && i_a_req && !b_win;
   end

   assign o_a_gnt     = a_win;
   assign o_b_gnt     = b_win;
   assign o_cpu_stall = i_a_req && !a_win;

   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (a_win) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_a_we;
         o_mem_addr  = i_a_addr;
         o_mem_wdata = i_a_wdata;
         o_mem_bmask = i_a_bmask;
      end else if (b_win) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_b_we;
         o_mem_addr  = i_b_addr;
         o_mem_wdata = i_b_wdata;
         o_mem_bmask = i_b_bmask;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= 4'd0;
      end else if (i_b_req && !b_win) begin
         starve_cnt <= sat_inc(starve_cnt);
      end else begin
         starve_cnt <= 4'd0;
      end
   end

   // Stage p1: owner of the access whose response arrives this cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         owner_p1 <= OWN_NONE;
         rd_p1    <= 1'b0;
      end else begin
         owner_p1 <= a_win ? OWN_A : (b_win ? OWN_B : OWN_NONE);
         rd_p1    <= a_win ? !i_a_we : (b_win ? !i_b_we : 1'b0);
      end
   end

   assign o_a_rvalid = (owner_p1 == OWN_A);
   assign o_b_rvalid = (owner_p1 == OWN_B);
   assign o_a_rdata  = (o_a_rvalid && rd_p1) ? i_mem_rdata : 32'd0;
   assign o_b_rdata  = (o_b_rvalid && rd_p1) ? i_mem_rdata : 32'd0;

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4, consecutive cycles B may be denied before it is forced to win (legal range 1-15).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_a_req / i_a_we  input  1/1  CPU LSU request and write enable; held stable until granted.
REQ-005 i_a_addr / i_a_wdata  input  32/32  CPU address and store data.
REQ-006 i_a_bmask  input  4  CPU byte-enable mask.
REQ-007 o_a_gnt / o_a_rvalid  output  1/1  CPU grant and response valid.
REQ-008 o_a_rdata  output  32  CPU load data.
REQ-009 i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_bmask  input  1,1,32,32,4  debug/DMA requester, same meaning as A.
REQ-010 o_b_gnt, o_b_rvalid, o_b_rdata  output  1,1,32  debug/DMA grant, response, load data.
REQ-011 o_mem_en / o_mem_we  output  1/1  shared data-memory/IO bus access strobe and write enable.
REQ-012 o_mem_addr, o_mem_wdata, o_mem_bmask  output  32,32,4  bus address, store data, byte mask.
REQ-013 i_mem_rdata  input  32  bus read data, valid exactly one cycle after o_mem_en.
REQ-014 o_cpu_stall  output  1  equals i_a_req AND NOT o_a_gnt.

Function
REQ-015 Grants are combinational: at most one of o_a_gnt/o_b_gnt high per cycle; a grant is issued only to an asserted request.
REQ-016 Default priority: A wins when both request.
REQ-017 Starvation counter (4 bits): increments each cycle i_b_req=1 and o_b_gnt=0; clears when o_b_gnt=1 or i_b_req=0; saturates at 15.
REQ-018 When counter >= STARVE_LIM and i_b_req=1, B wins over A that cycle.
REQ-019 When only one requester asserts, it is granted that cycle regardless of counter.
REQ-020 In a grant cycle, o_mem_en=1 and o_mem_we/addr/wdata/bmask mirror the granted requester; otherwise o_mem_en=0, o_mem_we=0, other bus outputs 0.
REQ-021 Owner tag register (none/A/B) captures the granted requester each cycle; o_x_rvalid asserts exactly one cycle after the grant, for reads and writes alike.
REQ-022 o_x_rdata = i_mem_rdata when o_x_rvalid=1 and the access was a read; 0 otherwise (writes and idle).
REQ-023 Back-to-back grants every cycle are legal; throughput one access/cycle, latency 1 cycle grant-to-rvalid.
REQ-024 Grant and rvalid for different requesters in the same cycle are legal and independent.
REQ-025 No request buffering: an ungranted request is not recorded; requester must hold it.

Reset
REQ-026 On i_rst_n=0 (asynchronously): owner tag = none, starvation counter = 0, o_a_rvalid = o_b_rvalid = 0, rdata outputs 0.
REQ-027 Reset asserted with a response pending discards that response; no rvalid after reset release.
REQ-028 While i_rst_n=0, grants and o_mem_en are forced 0 regardless of requests.
REQ-029 First grant possible in the first cycle after i_rst_n rises.

Verification
REQ-030 A read alone, addr 0x0000_0010, i_mem_rdata 0xDEADBEEF -> o_a_gnt same cycle, o_a_rvalid next cycle with o_a_rdata 0xDEADBEEF, o_b_rvalid 0.
REQ-031 A and B request continuously, STARVE_LIM=4 -> A granted 4 cycles, B on 5th, pattern AAAAB repeats; o_cpu_stall=1 only on B cycles.
REQ-032 B write 0x1234_5678 to 0x1000_0000 mask 4'b0011, A idle -> o_mem_en=1, o_mem_we=1, bus fields match; o_b_rvalid next cycle, o_b_rdata 0.
REQ-033 Alternating A-read/B-read every cycle -> each rvalid follows its own grant by one cycle, rdata routed to correct owner, no cycle lost.
REQ-034 Reset asserted the cycle after an A grant -> o_a_rvalid stays 0, counter 0; after release A request granted immediately.
REQ-035 B requests while A idle after 3 denials (counter=3) then A deasserts -> B granted, counter clears to 0 next cycle.
